// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile
// AXI4-Lite slave with a small register file:
//   0x00 CTRL     RW  (mirrored live on CTRL_OUT)
//   0x04 SCRATCH0 RW
//   0x08 SCRATCH1 RW
//   0x0C WR_COUNT RO  completed write-response handshakes
//   0x10 RD_COUNT RO  completed read-data handshakes
//   0x14-0x1C unmapped -> SLVERR, reads return 0
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*         write address / data / response channels
//   S_AXI_AR*/R*            read address / data channels
//   CTRL_OUT                live CTRL register value
//   o_dbg_state             {read FSM state, write FSM state}
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where VALID and READY are both 1; a VALID source holds its payload until
// that edge, and this slave holds BVALID/RVALID (and BRESP/RDATA/RRESP)
// stable until the master's READY completes the transfer.
module axi_lite_slave_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   CTRL_OUT,
  output logic [1:0]                      o_dbg_state
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = AW - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [IW-1:0] IDX_CTRL = IW'(0);
  localparam logic [IW-1:0] IDX_S0   = IW'(1);
  localparam logic [IW-1:0] IDX_S1   = IW'(2);
  localparam logic [IW-1:0] IDX_WRC  = IW'(3);
  localparam logic [IW-1:0] IDX_RDC  = IW'(4);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t r_w_state, w_w_state_nxt;
  r_state_t r_r_state, w_r_state_nxt;

  logic            r_aw_held, r_w_held;
  logic [IW-1:0]   r_aw_idx;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic [1:0]      r_bresp, r_rresp;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_ctrl, r_scratch0, r_scratch1;
  logic [31:0]     r_wr_count, r_rd_count;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_do_write;
  logic [IW-1:0] w_ar_idx;
  logic [DW-1:0] w_rd_mux;
  logic [1:0]    w_rd_resp;
  logic          w_unused;

  // PROT and the byte-offset address bits carry no meaning for this slave.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are gated by ARESET directly so they read 0 throughout reset
  // and 1 in the very first cycle after release.
  assign S_AXI_AWREADY = ~ARESET & (r_w_state == W_IDLE) & ~r_aw_held;
  assign S_AXI_WREADY  = ~ARESET & (r_w_state == W_IDLE) & ~r_w_held;
  assign S_AXI_BVALID  = (r_w_state == W_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = ~ARESET & (r_r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_r_state == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign CTRL_OUT      = r_ctrl;
  assign o_dbg_state   = {r_r_state, r_w_state};

  assign w_aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs     = S_AXI_WVALID & S_AXI_WREADY;
  assign w_b_hs     = S_AXI_BVALID & S_AXI_BREADY;
  assign w_ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_r_hs     = S_AXI_RVALID & S_AXI_RREADY;
  // The register update happens on the edge that enters W_RESP.
  assign w_do_write = (r_w_state == W_IDLE) & r_aw_held & r_w_held;
  assign w_ar_idx   = S_AXI_ARADDR[AW-1:2];

  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [DW/8-1:0] strb);
    f_merge = old_v;
    for (int i = 0; i < DW/8; i++)
      if (strb[i]) f_merge[8*i +: 8] = new_v[8*i +: 8];
  endfunction

  // FSM state registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_w_state <= W_IDLE;
      r_r_state <= R_IDLE;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_r_state <= w_r_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_r_state_nxt = r_r_state;
    case (r_w_state)
      W_IDLE: if (w_do_write)   w_w_state_nxt = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_w_state_nxt = W_IDLE;
      default:                  w_w_state_nxt = W_IDLE;
    endcase
    case (r_r_state)
      R_IDLE: if (S_AXI_ARVALID) w_r_state_nxt = R_DATA;
      R_DATA: if (S_AXI_RREADY)  w_r_state_nxt = R_IDLE;
      default:                   w_r_state_nxt = R_IDLE;
    endcase
  end

  // Read mux: unmapped offsets return 0 with SLVERR.
  always_comb begin
    w_rd_mux  = '0;
    w_rd_resp = RESP_OKAY;
    case (w_ar_idx)
      IDX_CTRL: w_rd_mux = r_ctrl;
      IDX_S0:   w_rd_mux = r_scratch0;
      IDX_S1:   w_rd_mux = r_scratch1;
      IDX_WRC:  w_rd_mux = DW'(r_wr_count);
      IDX_RDC:  w_rd_mux = DW'(r_rd_count);
      default:  w_rd_resp = RESP_SLVERR;
    endcase
  end

  // Write channel datapath and register file
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
      r_ctrl     <= '0;
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[AW-1:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      if (w_do_write) begin
        r_bresp <= (r_aw_idx <= IDX_RDC) ? RESP_OKAY : RESP_SLVERR;
        // Counter offsets fall through: accepted with OKAY, contents untouched.
        case (r_aw_idx)
          IDX_CTRL: r_ctrl     <= f_merge(r_ctrl, r_wdata, r_wstrb);
          IDX_S0:   r_scratch0 <= f_merge(r_scratch0, r_wdata, r_wstrb);
          IDX_S1:   r_scratch1 <= f_merge(r_scratch1, r_wdata, r_wstrb);
          default:  ;
        endcase
      end
      if (w_b_hs) begin
        r_aw_held  <= 1'b0;
        r_w_held   <= 1'b0;
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  // Read channel datapath; RDATA/RRESP only load in R_IDLE so they hold in R_DATA.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rd_count <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rdata <= w_rd_mux;
        r_rresp <= w_rd_resp;
      end
      if (w_r_hs) r_rd_count <= r_rd_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
module tb_axi_lite_slave_regfile;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, ctrl_out;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp, dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m_reg [3];
  logic [31:0] m_wr, m_rd;

  axi_lite_slave_regfile dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .CTRL_OUT(ctrl_out), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_reg[i] = 32'h0;
    m_wr = 32'h0;
    m_rd = 32'h0;
  endtask

  function automatic logic [1:0] m_resp(input logic [4:0] addr);
    return (addr / 4 < 5) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    int idx = addr / 4;
    if (idx < 3)  return m_reg[idx];
    if (idx == 3) return m_wr;
    if (idx == 4) return m_rd;
    return 32'h0;
  endfunction

  task automatic m_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = addr / 4;
    if (idx < 3)
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_reg[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  // ---------------- driver tasks ----------------
  // Presents AW after aw_dly cycles and W after w_dly cycles; returns at the
  // falling edge following the last of the two handshakes.
  task automatic send_aw_w(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, a_hs, d_hs;
    int c = 0;
    @(negedge ACLK);
    while (!(aw_done && w_done) && c < 40) begin
      awvalid = !aw_done && (c >= aw_dly);
      awaddr  = addr;
      awprot  = 3'($urandom_range(0, 7));
      wvalid  = !w_done && (c >= w_dly);
      wdata   = data;
      wstrb   = strb;
      #1;
      if (aw_done) chk("awready_after_accept", {31'b0, awready}, 32'd0);
      if (w_done)  chk("wready_after_accept", {31'b0, wready}, 32'd0);
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      @(negedge ACLK);
      if (a_hs) aw_done = 1;
      if (d_hs) w_done = 1;
      c++;
    end
    awvalid = 0;
    wvalid  = 0;
    chk("aw_w_accepted", {30'b0, aw_done, w_done}, 32'd3);
  endtask

  task automatic wait_bvalid();
    int n = 0;
    #1;
    while (!bvalid && n < 20) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    chk("b_latency", n, 1);
  endtask

  task automatic finish_b(input int b_dly, input logic [1:0] exp_resp);
    for (int i = 0; i < b_dly; i++) begin
      chk("bvalid_held", {31'b0, bvalid}, 32'd1);
      chk("bresp_held", {30'b0, bresp}, {30'b0, exp_resp});
      chk("no_new_aw_w", {30'b0, awready, wready}, 32'd0);
      @(negedge ACLK);
      #1;
    end
    bready = 1;
    #1;
    chk("bvalid", {31'b0, bvalid}, 32'd1);
    chk("bresp", {30'b0, bresp}, {30'b0, exp_resp});
    @(negedge ACLK);
    bready = 0;
    #1;
    chk("bvalid_clear", {31'b0, bvalid}, 32'd0);
    chk("ready_after_b", {30'b0, awready, wready}, 32'd3);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int aw_dly, input int w_dly, input int b_dly);
    send_aw_w(addr, data, strb, aw_dly, w_dly);
    m_write(addr, data, strb);
    wait_bvalid();
    finish_b(b_dly, m_resp(addr));
    m_wr = m_wr + 32'd1;
    chk("ctrl_out", ctrl_out, m_reg[0]);
  endtask

  task automatic rd(input logic [4:0] addr, input int r_dly);
    logic [31:0] exp_d = m_read(addr);
    logic [1:0]  exp_r = m_resp(addr);
    int c = 0;
    @(negedge ACLK);
    arvalid = 1;
    araddr  = addr;
    arprot  = 3'($urandom_range(0, 7));
    #1;
    while (!arready && c < 20) begin
      @(negedge ACLK);
      #1;
      c++;
    end
    @(negedge ACLK);
    arvalid = 0;
    #1;
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    chk("rdata", rdata, exp_d);
    chk("rresp", {30'b0, rresp}, {30'b0, exp_r});
    for (int i = 0; i < r_dly; i++) begin
      @(negedge ACLK);
      #1;
      chk("rdata_held", rdata, exp_d);
      chk("arready_low_in_data", {31'b0, arready}, 32'd0);
    end
    rready = 1;
    @(negedge ACLK);
    rready = 0;
    #1;
    chk("rvalid_clear", {31'b0, rvalid}, 32'd0);
    m_rd = m_rd + 32'd1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
    chk("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
    chk("rst_resps", {28'b0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ctrl_out", ctrl_out, 32'd0);
    chk("rst_dbg_state", {30'b0, dbg_state}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    ARESET = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    m_reset();
    repeat (3) @(negedge ACLK);
    #1;
    check_reset_outputs();
    @(negedge ACLK);
    ARESET = 0;
    #1;
    chk("ready_after_reset", {29'b0, awready, wready, arready}, 32'd7);

    // basic write/read of SCRATCH0 and both counters
    wr(5'h04, 32'hA5A5_1234, 4'hF, 0, 0, 0);
    rd(5'h04, 0);
    rd(5'h10, 0);
    rd(5'h0C, 0);

    // byte strobes on SCRATCH1
    wr(5'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    wr(5'h08, 32'h0000_0000, 4'b0101, 1, 0, 0);
    rd(5'h08, 2);

    // W three cycles ahead of AW, BREADY held off four cycles
    wr(5'h00, 32'h1357_9BDF, 4'hF, 3, 0, 4);

    // unmapped and read-only offsets
    wr(5'h18, 32'hDEAD_BEEF, 4'hF, 0, 2, 1);
    rd(5'h18, 1);
    wr(5'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
    rd(5'h0C, 0);

    // randomized traffic over the whole address range
    for (int i = 0; i < 40; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 1) == 1)
        wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 2));
      else
        rd(a, $urandom_range(0, 2));
    end

    // reset while a write response is pending
    send_aw_w(5'h00, 32'h0000_0001, 4'hF, 0, 0);
    m_write(5'h00, 32'h0000_0001, 4'hF);
    wait_bvalid();
    chk("ctrl_before_abort", ctrl_out, m_reg[0]);
    @(negedge ACLK);
    ARESET = 1;
    #1;
    m_reset();
    check_reset_outputs();
    @(negedge ACLK);
    ARESET = 0;
    #1;
    chk("ready_after_abort", {29'b0, awready, wready, arready}, 32'd7);
    rd(5'h10, 0);
    rd(5'h0C, 0);
    rd(5'h00, 0);

    // write counter wrap: preload all-ones, one more write wraps to zero
    @(negedge ACLK);
    force dut.r_wr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wr_count;
    m_wr = 32'hFFFF_FFFF;
    rd(5'h0C, 0);
    wr(5'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    rd(5'h0C, 0);
    rd(5'h04, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
